// File: rtl/yarp_pkg.sv
// Shared types and defaults for the YARP fetch front end.
package yarp_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          FETCH_QDEPTH     = 2;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_REQ,
      FETCH_WAIT
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/yarp_fetch_queue.sv
// Instruction buffer between fetch and decode: circular FIFO with flush.
module yarp_fetch_queue
   import yarp_pkg::*;
#(
   parameter int DEPTH = FETCH_QDEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  fetch_entry_t           push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output fetch_entry_t           head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full queue is accepted when the head leaves in the same cycle.
   assign pop_ok  = pop_i && !empty_o && !flush_i;
   assign push_ok = push_i && !flush_i && (!full_o || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/yarp_fetch_ctrl.sv
// PC generation and single-outstanding fetch sequencing into the instruction queue.
//   state      | meaning
//   FETCH_IDLE | no request; waiting for queue credit
//   FETCH_REQ  | request driven at pc_q, held until granted
//   FETCH_WAIT | granted, waiting for the read response
module yarp_fetch_ctrl
   import yarp_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          QDEPTH   = FETCH_QDEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_instr_o,
   output logic [31:0] fetch_pc_o,
   input  logic        fetch_ready_i,
   output logic        misalign_o
);

   fetch_state_e            state_q, state_d;
   logic [31:0]             pc_q, pc_d;
   logic                    drop_q, drop_d;
   logic                    misalign_q, misalign_d;

   fetch_entry_t            q_head, q_push_data;
   logic                    q_push, q_pop, q_full, q_empty;
   logic [$clog2(QDEPTH):0] q_count;
   logic [31:0]             occ_after;
   logic [31:0]             target_aligned;

   assign target_aligned = word_align(branch_target_i);
   assign q_pop          = fetch_ready_i && !q_empty && !branch_taken_i;
   assign q_push_data    = '{pc: pc_q, instr: imem_rdata_i};
   assign occ_after      = 32'(q_count) + 32'd1 - 32'(q_pop);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      q_push     = 1'b0;
      misalign_d = branch_taken_i && (branch_target_i[1:0] != 2'b00);
      case (state_q)
         FETCH_IDLE: begin
            if (branch_taken_i) begin
               pc_d    = target_aligned;
               state_d = FETCH_REQ;
            end else if (!q_full) begin
               state_d = FETCH_REQ;
            end
         end
         FETCH_REQ: begin
            if (imem_gnt_i) state_d = FETCH_WAIT;
            if (branch_taken_i) begin
               pc_d   = target_aligned;
               drop_d = imem_gnt_i;
            end
         end
         FETCH_WAIT: begin
            if (branch_taken_i) begin
               pc_d = target_aligned;
               if (imem_rvalid_i) begin
                  drop_d  = 1'b0;
                  state_d = FETCH_REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (imem_rvalid_i) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = FETCH_REQ;
               end else begin
                  q_push  = 1'b1;
                  pc_d    = pc_q + 32'd4;
                  state_d = (occ_after < 32'(QDEPTH)) ? FETCH_REQ : FETCH_IDLE;
               end
            end
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH_IDLE;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         misalign_q <= misalign_d;
      end
   end

   yarp_fetch_queue #(.DEPTH(QDEPTH)) u_queue (
      .clk         (clk),
      .reset       (reset),
      .push_i      (q_push),
      .push_data_i (q_push_data),
      .pop_i       (q_pop),
      .flush_i     (branch_taken_i),
      .head_o      (q_head),
      .count_o     (q_count),
      .full_o      (q_full),
      .empty_o     (q_empty)
   );

   assign imem_req_o    = (state_q == FETCH_REQ);
   assign imem_addr_o   = pc_q;
   assign misalign_o    = misalign_q;
   assign fetch_valid_o = !q_empty;
   assign fetch_instr_o = q_empty ? 32'h0 : q_head.instr;
   assign fetch_pc_o    = q_empty ? 32'h0 : q_head.pc;

endmodule

// File: tb/tb_yarp_fetch_ctrl.sv
// Bench for yarp_fetch_ctrl: memory responder, transaction-level model, directed scenarios.
module tb_yarp_fetch_ctrl;

   localparam int          QD  = 2;
   localparam logic [31:0] KEY = 32'h1357_9BDF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        branch_taken_i = 1'b0;
   logic [31:0] branch_target_i = 32'h0;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        fetch_ready_i = 1'b0;
   logic        imem_req_o, fetch_valid_o, misalign_o;
   logic [31:0] imem_addr_o, fetch_instr_o, fetch_pc_o;
   logic        hi_req, hi_valid, hi_mis;
   logic [31:0] hi_addr, hi_instr, hi_pc;

   int          checks = 0;
   int          errors = 0;

   int          pend_cnt = 0;
   logic [31:0] pend_addr = 32'h0;
   int          lat_extra = 0;
   logic        gnt_en = 1'b1;
   int          grant_cnt = 0;
   logic [31:0] last_gnt_addr = 32'hFFFF_FFFF;

   always #5 clk = ~clk;

   yarp_fetch_ctrl u_dut (
      .clk(clk), .reset(reset),
      .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
      .fetch_ready_i(fetch_ready_i), .misalign_o(misalign_o)
   );

   // Control timing is PC-independent, so this copy shares every input with u_dut.
   yarp_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
      .clk(clk), .reset(reset),
      .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
      .imem_req_o(hi_req), .imem_addr_o(hi_addr),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .fetch_valid_o(hi_valid), .fetch_instr_o(hi_instr), .fetch_pc_o(hi_pc),
      .fetch_ready_i(fetch_ready_i), .misalign_o(hi_mis)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One bus cycle: inputs change on the falling edge; memory grants and answers here.
   task automatic cyc(input logic rs, input logic br, input logic [31:0] tgt, input logic rdy);
      @(negedge clk);
      reset           = rs;
      branch_taken_i  = br;
      branch_target_i = tgt;
      fetch_ready_i   = rdy;
      imem_rvalid_i   = (pend_cnt == 1);
      imem_rdata_i    = (pend_cnt == 1) ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      if (pend_cnt != 0) pend_cnt--;
      imem_gnt_i = gnt_en && imem_req_o;
      if (imem_gnt_i) begin
         pend_cnt      = 1 + lat_extra;
         pend_addr     = imem_addr_o;
         grant_cnt++;
         last_gnt_addr = imem_addr_o;
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
   endtask

   // Model: fetch queue as a SV queue, bus tracked as request/outstanding flags.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;
   ent_t        mq[$];
   logic        m_init = 1'b0;
   logic        m_req = 1'b0, m_out = 1'b0, m_drop = 1'b0, m_mis = 1'b0;
   logic [31:0] m_pc = 32'h0;

   initial forever begin
      logic redir, pop, comp, grant, out_n, req_n;
      int   size_now;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_pc = 32'h0; m_req = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_mis = 1'b0;
         m_init = 1'b1;
      end else begin
         redir    = branch_taken_i;
         size_now = mq.size();
         pop      = fetch_ready_i && (size_now > 0) && !redir;
         comp     = m_out && imem_rvalid_i;
         grant    = m_req && imem_gnt_i;
         out_n    = grant || (m_out && !imem_rvalid_i);
         if (redir) mq.delete();
         else begin
            if (pop) void'(mq.pop_front());
            if (comp && !m_drop) mq.push_back('{m_pc, imem_rdata_i});
         end
         if (out_n)               req_n = 1'b0;
         else if (redir || m_req) req_n = 1'b1;
         else if (comp)           req_n = m_drop || (mq.size() < QD);
         else                     req_n = (size_now < QD);
         if (redir)                m_pc = branch_target_i & 32'hFFFF_FFFC;
         else if (comp && !m_drop) m_pc = m_pc + 32'd4;
         if (redir)     m_drop = out_n;
         else if (comp) m_drop = 1'b0;
         m_mis = redir && (branch_target_i % 4 != 0);
         m_out = out_n;
         m_req = req_n;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (m_init) begin
         chk("req", imem_req_o, m_req);
         chk("addr", imem_addr_o, m_pc);
         chk("valid", fetch_valid_o, mq.size() > 0);
         chk("head_pc", fetch_pc_o, (mq.size() > 0) ? mq[0].pc : 32'h0);
         chk("head_instr", fetch_instr_o, (mq.size() > 0) ? mq[0].instr : 32'h0);
         chk("misalign", misalign_o, m_mis);
      end
   end

   initial begin
      // Reset state, then back-to-back fetches with immediate grant and ready decode.
      do_reset();
      settle();
      chk("rst_req", imem_req_o, 0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_valid", fetch_valid_o, 0);
      chk("rst_instr", fetch_instr_o, 32'h0);
      chk("rst_hi_addr", hi_addr, 32'hFFFF_FFF8);
      cyc(0, 0, 0, 1); settle();
      chk("a_req_e0", imem_req_o, 1);
      chk("a_hi_req_e0", hi_req, 1);
      cyc(0, 0, 0, 1); settle();
      chk("a_valid_e1", fetch_valid_o, 0);
      cyc(0, 0, 0, 1); settle();
      chk("a_valid_e2", fetch_valid_o, 1);
      chk("a_pc0", fetch_pc_o, 32'h0);
      chk("a_instr0", fetch_instr_o, 32'h0 ^ KEY);
      chk("a_hi_valid", hi_valid, 1);
      chk("a_hi_pc0", hi_pc, 32'hFFFF_FFF8);
      chk("a_hi_instr0", hi_instr, 32'h0 ^ KEY);
      cyc(0, 0, 0, 1); settle();
      cyc(0, 0, 0, 1); settle();
      chk("a_pc1", fetch_pc_o, 32'h4);
      chk("a_hi_pc1", hi_pc, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 1); settle();
      cyc(0, 0, 0, 1); settle();
      chk("a_pc2", fetch_pc_o, 32'h8);
      chk("a_hi_pc2", hi_pc, 32'h0);
      chk("a_hi_mis", hi_mis, 0);

      // Decode stalled: queue fills, fetch idles; one pop buys exactly one request.
      do_reset();
      repeat (8) cyc(0, 0, 0, 0);
      settle();
      chk("b_full_req", imem_req_o, 0);
      chk("b_full_addr", imem_addr_o, 32'h8);
      chk("b_full_head", fetch_pc_o, 32'h0);
      grant_cnt = 0;
      cyc(0, 0, 0, 1);
      repeat (8) cyc(0, 0, 0, 0);
      settle();
      chk("b_grants", grant_cnt, 1);
      chk("b_gnt_addr", last_gnt_addr, 32'h8);
      chk("b_idle_req", imem_req_o, 0);
      chk("b_head", fetch_pc_o, 32'h4);

      // Redirect while waiting on 0x8: that response is dropped.
      lat_extra = 1;
      do_reset();
      last_gnt_addr = 32'hFFFF_FFFF;
      for (int i = 0; i < 30 && last_gnt_addr != 32'h8; i++) cyc(0, 0, 0, 1);
      chk("c_reach_wait8", last_gnt_addr, 32'h8);
      cyc(0, 1, 32'h100, 1); settle();
      chk("c_flush_valid", fetch_valid_o, 0);
      chk("c_new_pc", imem_addr_o, 32'h100);
      for (int i = 0; i < 20 && !fetch_valid_o; i++) begin
         cyc(0, 0, 0, 0); settle();
      end
      chk("c_valid", fetch_valid_o, 1);
      chk("c_pc", fetch_pc_o, 32'h100);
      chk("c_instr", fetch_instr_o, 32'h100 ^ KEY);

      // Grant withheld: request and address hold; misaligned redirect retargets at once.
      lat_extra = 0;
      gnt_en    = 1'b0;
      do_reset();
      cyc(0, 0, 0, 0); settle();
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0); settle();
         chk("d_hold_req", imem_req_o, 1);
         chk("d_hold_addr", imem_addr_o, 32'h0);
      end
      cyc(0, 1, 32'h202, 0); settle();
      chk("d_mis_pulse", misalign_o, 1);
      chk("d_mis_addr", imem_addr_o, 32'h200);
      chk("d_mis_req", imem_req_o, 1);
      cyc(0, 0, 0, 0); settle();
      chk("d_mis_end", misalign_o, 0);
      gnt_en = 1'b1;
      for (int i = 0; i < 20 && !fetch_valid_o; i++) begin
         cyc(0, 0, 0, 0); settle();
      end
      chk("d_pc", fetch_pc_o, 32'h200);

      // Reset while a fetch of 0x4 is in flight; its late response must be ignored.
      do_reset();
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      lat_extra = 2;
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      lat_extra = 0;
      cyc(0, 0, 0, 0);
      settle();
      for (int i = 0; i < 20 && !fetch_valid_o; i++) begin
         cyc(0, 0, 0, 0); settle();
      end
      chk("f_pc", fetch_pc_o, 32'h0);
      chk("f_instr", fetch_instr_o, 32'h0 ^ KEY);

      // Mixed directed pattern: redirects against grants/responses, stalls, latency, resets.
      for (int i = 0; i < 300; i++) begin
         lat_extra = i % 3;
         gnt_en    = (i % 5) != 1;
         cyc((i % 97) == 50, (i % 11) == 4, 32'(i) * 32'd52 + 32'(i % 4), (i % 3) != 0);
      end
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/yarp_fetch_ctrl.md
YARP_FETCH_CTRL -- requirements
Module: yarp_fetch_ctrl
Role: PC generation and fetch sequencing upstream of the instruction memory; buffers fetched instructions for decode.

Interface
- REQ-001: Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
- REQ-002: Parameter QDEPTH, default 2: instruction queue entries, power of two, ≥2.
- REQ-003: The block SHALL use one clock, `clk`; reset `reset` is synchronous and active-high.
- REQ-004: clk  in  1  rising-edge clock.
- REQ-005: reset  in  1  synchronous active-high reset.
- REQ-006: branch_taken_i  in  1  redirect request this cycle.
- REQ-007: branch_target_i  in  32  redirect address.
- REQ-008: imem_req_o  out  1  fetch request to instruction memory.
- REQ-009: imem_addr_o  out  32  fetch address, 4-byte aligned.
- REQ-010: imem_gnt_i  in  1  memory accepted request this cycle.
- REQ-011: imem_rvalid_i  in  1  read data valid; never in the grant cycle.
- REQ-012: imem_rdata_i  in  32  instruction word.
- REQ-013: fetch_valid_o  out  1  queue head valid.
- REQ-014: fetch_instr_o  out  32  queue head instruction.
- REQ-015: fetch_pc_o  out  32  queue head PC.
- REQ-016: fetch_ready_i  in  1  decode consumes head when fetch_valid_o=1.
- REQ-017: misalign_o  out  1  one-cycle pulse: redirect target[1:0]!=0.

Function
- REQ-018: FSM states IDLE, REQ, WAIT; at most one outstanding request.
- REQ-019: IDLE->REQ when occupancy < QDEPTH (credit check counts the in-flight response).
- REQ-020: REQ: imem_req_o=1, imem_addr_o=pc_q; address and req held stable until imem_gnt_i, except on redirect.
- REQ-021: REQ->WAIT on imem_gnt_i.
- REQ-022: WAIT on imem_rvalid_i: push {pc, rdata}, pc_q += 4 (mod 2^32, wraps 32'hFFFF_FFFC->0); ->REQ if space remains after push/pop, else ->IDLE.
- REQ-023: Queue push and pop in the same cycle SHALL both take effect; occupancy unchanged.
- REQ-024: Fetch latency: grant at cycle N, rvalid at N+1 → fetch_valid_o=1 at N+2 (queue registered, no bypass).
- REQ-025: fetch_valid_o=0 whenever queue empty; head outputs stable while valid and not ready.
- REQ-026: Redirect (branch_taken_i=1) has priority: flush queue (fetch_valid_o=0 next cycle), pc_q <= {target[31:2],2'b00}, pop ignored.
- REQ-027: Redirect while in WAIT, or coincident with imem_gnt_i: set drop flag; the next imem_rvalid_i is discarded, pc_q not incremented; then ->REQ.
- REQ-028: Redirect in REQ without grant: retract; next cycle imem_addr_o = new target.
- REQ-029: Redirect in IDLE: ->REQ next cycle at new target.
- REQ-030: Redirect and rvalid in the same cycle: response discarded.
- REQ-031: misalign_o pulses one cycle after redirect with target[1:0]!=0; fetch proceeds at the aligned address.
- REQ-032: imem_rvalid_i with no outstanding request is ignored.

Reset
- REQ-033: On reset: FSM=IDLE, pc_q=RESET_PC, queue empty, drop flag clear; imem_req_o=0, imem_addr_o=RESET_PC, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=0, misalign_o=0.
- REQ-034: First cycle after reset deassertion: IDLE->REQ; imem_req_o=1 one cycle after reset release.
- REQ-035: Reset mid-request aborts it; a later stale imem_rvalid_i is ignored (REQ-032).

Structure
- REQ-036: yarp_pkg holds RESET_PC default, FETCH_QDEPTH, typedef fetch_state_e, and struct fetch_entry_t {pc[31:0], instr[31:0]}.
- REQ-037: The queue is sub-module yarp_fetch_queue (push/pop/flush, count, full/empty); FSM and PC logic stay in yarp_fetch_ctrl.

Verification
- REQ-038: Reset release, gnt at once, rvalid one cycle later, ready=1 → instrs at PC 0x0, 0x4, 0x8 in order; first fetch_valid_o=1 three cycles after reset release.
- REQ-039: ready=0 with two responses → queue full, imem_req_o=0, FSM IDLE; ready=1 for one cycle → exactly one new request to 0x8.
- REQ-040: Redirect to 0x100 while WAIT on 0x8 → 0x8 response dropped; next delivered fetch_pc_o=0x100.
- REQ-041: Redirect to 0x202 → misalign_o=1 for one cycle; fetch at 0x200.
- REQ-042: gnt withheld 5 cycles → imem_addr_o constant, req high throughout; redirect then changes address next cycle.
- REQ-043: RESET_PC=32'hFFFF_FFF8, two fetches → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0.
